// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the byte-writable data memory.
// Helpers work on a fixed maximum width; callers slice down to their own word size.
package dmem_pkg;

  localparam int unsigned MAX_BYTES  = 64;
  localparam int unsigned MAX_WIDTH  = MAX_BYTES * 8;
  localparam int unsigned MAX_LANE_W = 6;

  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  typedef enum logic {
    S_IDLE,
    S_RESP
  } state_t;

  function automatic logic [MAX_BYTES-1:0] lane_mask(
    input logic                  size,
    input logic [MAX_LANE_W-1:0] lane,
    input int unsigned           nBytes
  );
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      m[i] = (size == SIZE_WORD) ? (i < nBytes) : (i == 32'(lane));
    end
    return m;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] byte_extract(
    input logic [MAX_WIDTH-1:0]  word,
    input logic [MAX_LANE_W-1:0] lane
  );
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    r[7:0] = word[{lane, 3'b000} +: 8];
    return r;
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// DEPTH x DATA_WIDTH storage with per-byte write enables and a registered read port.
module dmem_byte_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                       clk,
  input  logic                       wrEn,
  input  logic [DATA_WIDTH/8-1:0]    byteEn,
  input  logic [$clog2(DEPTH)-1:0]   idx,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic                       rdEn,
  output logic [DATA_WIDTH-1:0]      rdata
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (byteEn[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (rdEn) rdata <= mem[idx];
  end

endmodule

// File: rtl/data_memory_bw.sv
// Byte-addressable data memory for LDR/STR/LDRB/STRB with valid/ready request and
// response channels, a registered one-cycle read, and a saturating error counter.
module data_memory_bw
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DEPTH         = 1024,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic                     req_size,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int unsigned BYTES    = DATA_WIDTH / 8;
  localparam int unsigned LANE_W   = $clog2(BYTES);
  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam int unsigned MEM_BITS = IDX_W + LANE_W;

  state_t state, stateNext;

  logic [LANE_W-1:0]        lane;
  logic [IDX_W-1:0]         idx;
  logic                     outOfRange;
  logic                     misaligned;
  logic                     err;
  logic                     accept;
  logic [MAX_BYTES-1:0]     maskFull;
  logic [DATA_WIDTH-1:0]    wdataEff;
  logic                     wrEn;
  logic                     rdEn;
  logic [DATA_WIDTH-1:0]    rdWord;
  logic [MAX_WIDTH-1:0]     extFull;
  logic                     unusedBits;

  logic                     respLoad;
  logic                     respByte;
  logic [LANE_W-1:0]        respLane;
  logic                     respErrQ;
  logic [ERR_CNT_WIDTH-1:0] errCnt;

  assign lane = req_addr[LANE_W-1:0];
  assign idx  = req_addr[MEM_BITS-1:LANE_W];

  if (ADDR_WIDTH > MEM_BITS) begin : gHighBits
    assign outOfRange = |req_addr[ADDR_WIDTH-1:MEM_BITS];
  end else begin : gNoHighBits
    assign outOfRange = 1'b0;
  end

  assign misaligned = (req_size == SIZE_WORD) && (lane != '0);
  assign err        = outOfRange || misaligned;

  assign req_ready = !reset && (!resp_valid || resp_ready);
  assign accept    = req_valid && req_ready;

  assign maskFull = lane_mask(req_size, MAX_LANE_W'(lane), BYTES);
  assign wdataEff = (req_size == SIZE_BYTE) ? {BYTES{req_wdata[7:0]}} : req_wdata;
  assign wrEn     = accept && req_write && !err;
  assign rdEn     = accept && !req_write && !err;

  dmem_byte_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) uArray (
    .clk    (clk),
    .wrEn   (wrEn),
    .byteEn (maskFull[BYTES-1:0]),
    .idx    (idx),
    .wdata  (wdataEff),
    .rdEn   (rdEn),
    .rdata  (rdWord)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      respLoad <= 1'b0;
      respByte <= 1'b0;
      respLane <= '0;
      respErrQ <= 1'b0;
      errCnt   <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        respLoad <= !req_write && !err;
        respByte <= (req_size == SIZE_BYTE);
        respLane <= lane;
        respErrQ <= err;
        if (err && (errCnt != '1)) errCnt <= errCnt + ERR_CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    stateNext  = state;
    resp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) stateNext = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready && !accept) stateNext = S_IDLE;
      end
      default: stateNext = S_IDLE;
    endcase
  end

  // Read data stays in the array's output register until the next accepted load,
  // so lane selection is applied here from the latched request attributes.
  assign extFull = byte_extract(MAX_WIDTH'(rdWord), MAX_LANE_W'(respLane));

  always_comb begin
    resp_rdata = '0;
    if (respLoad) resp_rdata = respByte ? extFull[DATA_WIDTH-1:0] : rdWord;
  end

  assign resp_err   = respErrQ;
  assign err_count  = errCnt;
  assign unusedBits = ^{maskFull[MAX_BYTES-1:BYTES], extFull[MAX_WIDTH-1:DATA_WIDTH]};

endmodule

// File: tb/tb_data_memory_bw.sv
// Self-checking bench for data_memory_bw: directed vector table, hand-written
// backpressure/reset sequences, and randomized traffic against a byte-array model.
module tb_data_memory_bw;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [15:0] err_count;

  data_memory_bw #(
    .DATA_WIDTH    (32),
    .DEPTH         (1024),
    .ADDR_WIDTH    (32),
    .ERR_CNT_WIDTH (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: a flat byte array, little-endian lanes, 4 KiB address space.
  logic [7:0]  mMem [4096];
  int unsigned mErr = 0;

  function automatic void model(input logic w, input logic s, input logic [31:0] a,
                                input logic [31:0] d, output logic [31:0] r, output logic e);
    e = (a >= 32'd4096) || (!s && (a % 4 != 0));
    r = '0;
    if (e) begin
      if (mErr < 32'hFFFF) mErr++;
    end else if (w) begin
      if (s) mMem[a[11:0]] = d[7:0];
      else for (int i = 0; i < 4; i++) mMem[a[11:0] + 12'(i)] = d[8*i +: 8];
    end else begin
      if (s) r[7:0] = mMem[a[11:0]];
      else for (int i = 0; i < 4; i++) r[8*i +: 8] = mMem[a[11:0] + 12'(i)];
    end
  endfunction

  // Starts just after a negedge; returns at the negedge one cycle after acceptance.
  task automatic send(input logic w, input logic s, input logic [31:0] a, input logic [31:0] d,
                      output logic rv, output logic [31:0] rd, output logic re, output logic [15:0] rc);
    int n;
    req_valid = 1'b1; req_write = w; req_size = s; req_addr = a; req_wdata = d;
    resp_ready = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n == 20) chk("req_ready_timeout", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rv = resp_valid; rd = resp_rdata; re = resp_err; rc = err_count;
  endtask

  typedef struct {
    logic        w;
    logic        s;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] er;
    logic        ee;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl [20];

  initial begin
    logic        rv, re, ee;
    logic [31:0] rd, er;
    logic [15:0] rc;

    tbl[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 1'b1, 32'h0000_0012, 32'h0000_00AA, 32'h0000_0000, 1'b0, 16'd0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAA_BEEF, 1'b0, 16'd0};
    tbl[4]  = '{1'b0, 1'b1, 32'h0000_0013, 32'h0,         32'h0000_00DE, 1'b0, 16'd0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h1122_3344, 32'h0000_0000, 1'b0, 16'd0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0000_0011, 32'h0,         32'h0000_0000, 1'b1, 16'd1};
    tbl[7]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h1234_5678, 32'h0000_0000, 1'b1, 16'd2};
    tbl[8]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h1122_3344, 1'b0, 16'd2};
    tbl[9]  = '{1'b1, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 16'd2};
    tbl[10] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         32'hCAFE_F00D, 1'b0, 16'd2};
    tbl[11] = '{1'b1, 1'b0, 32'h0000_0030, 32'h0BAD_F00D, 32'h0000_0000, 1'b0, 16'd2};
    tbl[12] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0102_0304, 32'h0000_0000, 1'b0, 16'd2};
    tbl[13] = '{1'b1, 1'b1, 32'h0000_0FFF, 32'hFFFF_FF5A, 32'h0000_0000, 1'b0, 16'd2};
    tbl[14] = '{1'b0, 1'b0, 32'h0000_0FFC, 32'h0,         32'h5A02_0304, 1'b0, 16'd2};
    tbl[15] = '{1'b0, 1'b1, 32'h0000_1003, 32'h0,         32'h0000_0000, 1'b1, 16'd3};
    tbl[16] = '{1'b1, 1'b1, 32'h0000_0011, 32'h0000_0077, 32'h0000_0000, 1'b0, 16'd3};
    tbl[17] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAA_77EF, 1'b0, 16'd3};
    tbl[18] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 1'b1, 16'd4};
    tbl[19] = '{1'b0, 1'b1, 32'h0000_0FFE, 32'h0,         32'h0000_0002, 1'b0, 16'd4};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("req_ready_in_reset", {31'b0, req_ready}, 32'd0);
    chk("resp_valid_in_reset", {31'b0, resp_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_err_count", {16'b0, err_count}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Directed vectors, issued back-to-back.
    for (int i = 0; i < 20; i++) begin
      model(tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d, er, ee);
      send(tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d, rv, rd, re, rc);
      chk($sformatf("vec%0d_valid", i), {31'b0, rv}, 32'd1);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].er);
      chk($sformatf("vec%0d_err", i), {31'b0, re}, {31'b0, tbl[i].ee});
      chk($sformatf("vec%0d_cnt", i), {16'b0, rc}, {16'b0, tbl[i].ec});
    end

    // Backpressure: response held for 3 cycles with a request waiting, then full rate.
    req_valid = 1'b1; req_write = 1'b0; req_size = 1'b0; req_addr = 32'h10; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; req_addr = 32'h20;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      chk("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("bp_rdata_stable", resp_rdata, 32'hDEAA_77EF);
    end
    resp_ready = 1'b1;
    #1 chk("bp_release_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_addr = 32'h0;
    @(negedge clk);
    chk("b2b_valid0", {31'b0, resp_valid}, 32'd1);
    chk("b2b_rdata0", resp_rdata, 32'hCAFE_F00D);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid1", {31'b0, resp_valid}, 32'd1);
    chk("b2b_rdata1", resp_rdata, 32'h1122_3344);

    // Reset while a response is pending and a store is presented.
    req_valid = 1'b1; req_write = 1'b0; req_size = 1'b0; req_addr = 32'h10; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hAAAA_5555; resp_ready = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("rstp_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rstp_valid_before", {31'b0, resp_valid}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    mErr = 0;
    @(negedge clk);
    chk("rstp_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rstp_rdata", resp_rdata, 32'd0);
    chk("rstp_err", {31'b0, resp_err}, 32'd0);
    chk("rstp_err_count", {16'b0, err_count}, 32'd0);
    send(1'b0, 1'b0, 32'h30, 32'h0, rv, rd, re, rc);
    chk("rstp_no_store", rd, 32'h0BAD_F00D);

    // Fill the low region so random loads always read defined data.
    for (int i = 0; i < 64; i++) begin
      logic [31:0] d;
      d = $urandom;
      model(1'b1, 1'b0, 32'(i * 4), d, er, ee);
      send(1'b1, 1'b0, 32'(i * 4), d, rv, rd, re, rc);
      chk("fill_err", {31'b0, re}, {31'b0, ee});
    end

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, d;
      logic        w, s;
      int          stall;
      case ($urandom_range(0, 9))
        0:       a = 32'h1000 + $urandom_range(0, 4095);
        1:       a = $urandom | 32'h8000_0000;
        default: a = $urandom_range(0, 255);
      endcase
      w = 1'($urandom); s = 1'($urandom); d = $urandom;
      model(w, s, a, d, er, ee);
      send(w, s, a, d, rv, rd, re, rc);
      chk("rnd_valid", {31'b0, rv}, 32'd1);
      chk("rnd_rdata", rd, er);
      chk("rnd_err", {31'b0, re}, {31'b0, ee});
      chk("rnd_cnt", {16'b0, rc}, mErr);
      stall = $urandom_range(0, 2);
      resp_ready = 1'b0;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        chk("rnd_hold_valid", {31'b0, resp_valid}, 32'd1);
        chk("rnd_hold_rdata", resp_rdata, er);
        chk("rnd_hold_ready", {31'b0, req_ready}, 32'd0);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_bw.md
Name: data_memory_bw

Overview:
Parametrised, byte-addressable data memory for the ARM datapath, serving LDR/STR/LDRB/STRB.
- Requests use a valid/ready handshake; responses use a valid/ready handshake with backpressure and a registered one-cycle read.
- Detects misaligned word accesses and out-of-range addresses, and counts them.
- Sits between the MEM stage and on-chip storage.

Parameters:
DATA_WIDTH, 32, word width in bits; multiple of 8; BYTES = DATA_WIDTH/8, power of two.
DEPTH, 1024, number of words; power of two.
ADDR_WIDTH, 32, byte-address width; must be ≥ log2(DEPTH*BYTES).
ERR_CNT_WIDTH, 16, width of saturating error counter.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_write  in  1  1 = store, 0 = load
req_size  in  1  0 = word, 1 = byte
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data; a byte store uses bits [7:0]
resp_valid  out  1  response present
resp_ready  in  1  response consumed when resp_valid && resp_ready
resp_rdata  out  DATA_WIDTH  load data; byte loads are zero-extended; 0 for stores and errors
resp_err  out  1  access was misaligned or out of range
err_count  out  ERR_CNT_WIDTH  saturating count of erroring requests

Behaviour:
- Address decode:
  - word index = req_addr[log2(DEPTH*BYTES)-1 : log2(BYTES)]
  - byte lane = req_addr[log2(BYTES)-1 : 0]
- Error conditions:
  - out-of-range: req_addr >= DEPTH*BYTES
  - misaligned: req_size = word and lane != 0
  - err = out-of-range OR misaligned
- Handshake:
  - req_ready = !reset && (!resp_valid || resp_ready); single-entry response register; at most one outstanding request.
  - Accepting a request in cycle N gives resp_valid = 1 in cycle N+1.
  - resp_valid and its payload stay stable until consumed.
- FSM, two states:
  - IDLE: resp_valid = 0. Accept → RESP.
  - RESP: resp_valid = 1. If consumed with no new accept → IDLE. If consumed with a new accept in the same cycle → stay in RESP with the new payload (back-to-back, full throughput).
- Store (accepted, no err):
  - Word: all byte enables set.
  - Byte: only the lane enable; that lane takes req_wdata[7:0]; other bytes of the word are unchanged (no read-modify-write).
  - Response: rdata = 0, err = 0.
- Load (accepted, no err):
  - Registered read of the word.
  - Word: rdata = word.
  - Byte: rdata = {zeros, selected byte}.
- Error request (accepted): no memory write; response rdata = 0, err = 1; err_count increments and saturates at all-ones.
- Ordering: a store accepted in cycle N is visible to a load accepted in cycle N+1 or later.
- Reset (synchronous, highest priority):
  - resp_valid = 0, resp_rdata = 0, resp_err = 0, err_count = 0, state = IDLE.
  - No memory write occurs in a reset cycle.
  - A pending response is discarded.
  - Memory contents are not initialised and are X until written.
- Inputs are ignored when not accepted; storage is never written without acceptance.

Decomposition:
- Package dmem_pkg:
  - SIZE_WORD = 1'b0, SIZE_BYTE = 1'b1
  - FSM state enum {S_IDLE, S_RESP}
  - function lane_mask(size, lane) → BYTES-bit enable
  - function byte_extract(word, lane) → zero-extended word
- Sub-module dmem_byte_array: DEPTH × DATA_WIDTH storage with per-byte write enables and a registered read port; instantiated once.
- The top level holds the decode, error check, FSM, response register and counter.

Test Plan:
1. Store word 0xDEADBEEF @ 0x10, then load word @ 0x10 → response rdata = 0xDEADBEEF, err = 0, resp_valid exactly one cycle after accept.
2. After scenario 1, store byte 0xAA @ 0x12, then load word @ 0x10 → 0xDEAABEEF; load byte @ 0x13 → 0x000000DE.
3. Load word @ 0x11 → err = 1, rdata = 0, err_count = 1. Store word @ 0x1000 (DEPTH = 1024) → err = 1, memory unchanged, err_count = 2.
4. Hold resp_ready = 0 for 3 cycles with req_valid = 1 → req_ready = 0 and the response stays stable. Then resp_ready = 1 with back-to-back loads → one response per cycle.
5. Store word @ 0x20 in cycle N, load word @ 0x20 in cycle N+1 → new data returned.
6. Assert reset while resp_valid = 1 and a store is presented → resp_valid = 0, err_count = 0, req_ready = 0, and a later load shows the store did not occur.
